// File: rtl/call_stack_ctrl_pkg.sv
// Shared definitions for the return-address stack controller: default sizes,
// FSM state encodings and the call/return strobe decode.
package call_stack_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_ERROR = 1'b1;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic call, input logic ret);
    stack_op_e op;
    op = OP_NONE;
    if (call && ret) begin
      op = OP_SWAP;
    end else if (ret) begin
      op = OP_POP;
    end else if (call) begin
      op = OP_PUSH;
    end
    return op;
  endfunction

endpackage

// File: rtl/call_stack_ctrl_mem.sv
// DEPTH x ADDR_W storage for the return-address stack.
// One synchronous write port, one asynchronous read port; contents are not reset.
module call_stack_ctrl_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: pushes PC+1 on call, pops a registered return
// address with a one-cycle valid pulse on return. Build macro CALL_STACK_WRAP_EN
// makes a call on a full stack overwrite the oldest entry instead of freezing in ERROR.
module call_stack_ctrl
  import call_stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_call,
  input  logic              i_return,
  input  logic [ADDR_W-1:0] i_pc_ret,
  input  logic              i_clr_err,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic              o_ret_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_depth,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  sp_q, sp_d, sp_inc, sp_dec;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_rdata;
  logic              empty, full;
  stack_op_e         op;

  assign sp_inc = sp_q + PTR_W'(1);
  assign sp_dec = sp_q - PTR_W'(1);
  assign empty  = (depth_q == '0);
  assign full   = (depth_q == CNT_W'(DEPTH));
  assign op     = decode_op(i_call, i_return);

  // Top of stack always sits at sp-1, so the read port is hard-wired there.
  call_stack_ctrl_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (mem_waddr),
    .i_wdata (i_pc_ret),
    .i_raddr (sp_dec),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    sp_d        = sp_q;
    depth_d     = depth_q;
    state_d     = state_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;

    if (i_en) begin
      if (i_clr_err) begin
        sp_d    = '0;
        depth_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = ST_RUN;
      end else if (state_q == ST_RUN) begin
        unique case (op)
          OP_NONE: begin
          end
          OP_PUSH: begin
            if (!full) begin
              mem_we  = 1'b1;
              sp_d    = sp_inc;
              depth_d = depth_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
              // sp already points at the oldest entry when full; overwrite it.
              mem_we = 1'b1;
              sp_d   = sp_inc;
`else
              state_d = ST_ERROR;
`endif
            end
          end
          OP_POP, OP_SWAP: begin
            if (empty) begin
              // A swap on empty behaves as a bare underflowing return.
              unf_d      = 1'b1;
              ret_addr_d = '0;
              state_d    = ST_ERROR;
            end else begin
              ret_addr_d  = mem_rdata;
              ret_valid_d = 1'b1;
              if (op == OP_SWAP) begin
                mem_we    = 1'b1;
                mem_waddr = sp_dec;
              end else begin
                sp_d    = sp_dec;
                depth_d = depth_q - CNT_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sp_q        <= '0;
      depth_q     <= '0;
      state_q     <= ST_RUN;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      state_q     <= state_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign o_ret_addr  = ret_addr_q;
  assign o_ret_valid = ret_valid_q;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_depth     = depth_q;
  assign o_ovf       = ovf_q;
  assign o_unf       = unf_q;

endmodule
